// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbitration of NUM_REQ requesters onto one shared
// signed add/subtract datapath, with a single-entry valid/ready response buffer.
// Optional feature macro: ADDER_ARB_SAT_EN (saturate rsp_out on signed overflow).
module adder_arbiter #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ID_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_op,
    input  logic [NUM_REQ*WIDTH-1:0]   req_x,
    input  logic [NUM_REQ*WIDTH-1:0]   req_y,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [WIDTH-1:0]           rsp_out,
    output logic                       rsp_cout,
    output logic                       rsp_ov
);

    localparam int unsigned SUM_W = WIDTH + 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic [WIDTH-1:0]   r_out;
    logic               r_cout;
    logic               r_ov;

    logic               w_can_accept;
    logic               w_grant;
    logic [NUM_REQ-1:0] w_gnt_vec;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic [WIDTH-1:0]   w_x;
    logic [WIDTH-1:0]   w_y;
    logic               w_op;
    logic [WIDTH-1:0]   w_yy;
    logic [SUM_W-1:0]   w_sum;
    logic               w_c_msb;
    logic               w_ov;
    logic [WIDTH-1:0]   w_res;

    assign w_can_accept = (r_state == ST_EMPTY) || rsp_ready;

    // Round-robin scan from the pointer; no grant in reset or while the buffer is blocked.
    always_comb begin
        int unsigned v_idx;
        w_gnt_vec = '0;
        w_gnt_idx = '0;
        w_ptr_nxt = r_ptr;
        w_grant   = 1'b0;
        v_idx     = 0;
        if (rst_n && w_can_accept) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                v_idx = 32'(r_ptr) + k;
                if (v_idx >= NUM_REQ) begin
                    v_idx = v_idx - NUM_REQ;
                end
                if (!w_grant && req_valid[v_idx]) begin
                    w_grant          = 1'b1;
                    w_gnt_vec[v_idx] = 1'b1;
                    w_gnt_idx        = ID_W'(v_idx);
                    w_ptr_nxt        = (v_idx + 1 >= NUM_REQ) ? '0 : ID_W'(v_idx + 1);
                end
            end
        end
    end

    assign req_ready = w_gnt_vec;

    // Operand mux driven by the one-hot grant.
    always_comb begin
        w_x  = '0;
        w_y  = '0;
        w_op = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_vec[i]) begin
                w_x  = req_x[i*WIDTH +: WIDTH];
                w_y  = req_y[i*WIDTH +: WIDTH];
                w_op = req_op[i];
            end
        end
    end

    // Shared adder: subtract is x + ~y + 1; overflow is carry-in vs carry-out of the MSB.
    always_comb begin
        w_yy    = w_y ^ {WIDTH{w_op}};
        w_sum   = {1'b0, w_x} + {1'b0, w_yy} + SUM_W'(w_op);
        w_c_msb = w_x[WIDTH-1] ^ w_yy[WIDTH-1] ^ w_sum[WIDTH-1];
        w_ov    = w_sum[WIDTH] ^ w_c_msb;
`ifdef ADDER_ARB_SAT_EN
        if (w_ov) begin
            w_res = w_x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            w_res = w_sum[WIDTH-1:0];
        end
`else
        w_res = w_sum[WIDTH-1:0];
`endif
    end

    // Buffer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Buffer next state: a grant always fills; a drain without refill empties.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_grant) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (rsp_ready && !w_grant) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Round-robin pointer and response payload, updated only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_id   <= '0;
            r_out  <= '0;
            r_cout <= 1'b0;
            r_ov   <= 1'b0;
        end else if (w_grant) begin
            r_ptr  <= w_ptr_nxt;
            r_id   <= w_gnt_idx;
            r_out  <= w_res;
            r_cout <= w_sum[WIDTH];
            r_ov   <= w_ov;
        end
    end

    assign rsp_valid = (r_state == ST_FULL);
    assign rsp_id    = r_id;
    assign rsp_out   = r_out;
    assign rsp_cout  = r_cout;
    assign rsp_ov    = r_ov;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed, table-driven bench for adder_arbiter plus hand-written
// round-robin, backpressure, reset and single-requester sequences.
module tb_adder_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_op;
    logic [47:0] req_x;
    logic [47:0] req_y;
    logic [2:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_out;
    logic        rsp_cout;
    logic        rsp_ov;

    int n_checks = 0;
    int n_errors = 0;

    adder_arbiter #(.WIDTH(16), .NUM_REQ(3), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_out   (rsp_out),
        .rsp_cout  (rsp_cout),
        .rsp_ov    (rsp_ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic [2:0]  op;
        logic [47:0] x;
        logic [47:0] y;
        logic [2:0]  exp_ready;
        logic        exp_valid;
        logic [1:0]  exp_id;
        logic [15:0] exp_out;
        logic        exp_cout;
        logic        exp_ov;
    } vec_t;

`ifdef ADDER_ARB_SAT_EN
    localparam logic [15:0] E_V0 = 16'h7FFF;
    localparam logic [15:0] E_V2 = 16'h8000;
    localparam logic [15:0] E_V7 = 16'h8000;
`else
    localparam logic [15:0] E_V0 = 16'h8000;
    localparam logic [15:0] E_V2 = 16'h7FFF;
    localparam logic [15:0] E_V7 = 16'h0000;
`endif

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rsp(input string tag, input logic [1:0] id, input logic [15:0] out,
                             input logic cout, input logic ov);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, " rsp_id"},    32'(rsp_id),    32'(id));
        chk({tag, " rsp_out"},   32'(rsp_out),   32'(out));
        chk({tag, " rsp_cout"},  32'(rsp_cout),  32'(cout));
        chk({tag, " rsp_ov"},    32'(rsp_ov),    32'(ov));
    endtask

    initial begin
        logic [1:0]  hold_id;
        logic [15:0] hold_out;
        logic [1:0]  g;

        // valid, op, x{2,1,0}, y{2,1,0}, ready, rsp_valid, id, out, cout, ov
        vecs[0] = '{3'b001, 3'b000, {16'h0, 16'h0, 16'h7FFF}, {16'h0, 16'h0, 16'h0001},
                    3'b001, 1'b1, 2'd0, E_V0, 1'b0, 1'b1};
        vecs[1] = '{3'b010, 3'b010, {16'h0, 16'h0005, 16'h0}, {16'h0, 16'h0007, 16'h0},
                    3'b010, 1'b1, 2'd1, 16'hFFFE, 1'b0, 1'b0};
        vecs[2] = '{3'b100, 3'b100, {16'h8000, 16'h0, 16'h0}, {16'h0001, 16'h0, 16'h0},
                    3'b100, 1'b1, 2'd2, E_V2, 1'b1, 1'b1};
        vecs[3] = '{3'b000, 3'b000, 48'h0, 48'h0,
                    3'b000, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0};
        vecs[4] = '{3'b101, 3'b000, {16'hFFFF, 16'h0, 16'h1234}, {16'h0001, 16'h0, 16'h1111},
                    3'b001, 1'b1, 2'd0, 16'h2345, 1'b0, 1'b0};
        vecs[5] = '{3'b101, 3'b000, {16'hFFFF, 16'h0, 16'h1234}, {16'h0001, 16'h0, 16'h1111},
                    3'b100, 1'b1, 2'd2, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{3'b110, 3'b010, {16'h0, 16'h0000, 16'h0}, {16'h0, 16'h0000, 16'h0},
                    3'b010, 1'b1, 2'd1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{3'b011, 3'b000, {16'h0, 16'h0, 16'h8000}, {16'h0, 16'h0, 16'h8000},
                    3'b001, 1'b1, 2'd0, E_V7, 1'b1, 1'b1};

        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b1;
        req_valid = 3'b111;

        // Reset state
        @(negedge clk);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_id",    32'(rsp_id),    32'd0);
        chk("reset rsp_out",   32'(rsp_out),   32'd0);
        chk("reset rsp_cout",  32'(rsp_cout),  32'd0);
        chk("reset rsp_ov",    32'(rsp_ov),    32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        rst_n     = 1'b1;

        // Table-driven vectors, one per cycle, consumer always ready
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            req_valid = vecs[v].valid;
            req_op    = vecs[v].op;
            req_x     = vecs[v].x;
            req_y     = vecs[v].y;
            #1;
            chk($sformatf("vec%0d req_ready", v), 32'(req_ready), 32'(vecs[v].exp_ready));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d rsp_valid", v), 32'(rsp_valid), 32'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) begin
                check_rsp($sformatf("vec%0d", v), vecs[v].exp_id, vecs[v].exp_out,
                          vecs[v].exp_cout, vecs[v].exp_ov);
            end
        end

        // Steer pointer back to 0 via a lone grant to requester 2
        @(negedge clk);
        req_valid = 3'b100;
        req_op    = '0;
        req_x     = {16'd3, 16'd2, 16'd1};
        req_y     = '0;
        #1;
        chk("steer req_ready", 32'(req_ready), 32'b100);
        @(posedge clk);

        // All three requesters continuously: order 0,1,2,0,1,2, no bubbles
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            req_valid = 3'b111;
            g = 2'(k % 3);
            #1;
            chk($sformatf("rr%0d req_ready", k), 32'(req_ready), 32'(3'b001 << g));
            @(posedge clk);
            #1;
            check_rsp($sformatf("rr%0d", k), g, 16'(g) + 16'd1, 1'b0, 1'b0);
        end

        // Backpressure: fill with requester 0, then stall three cycles
        @(negedge clk);
        #1;
        chk("bp fill req_ready", 32'(req_ready), 32'b001);
        @(posedge clk);
        #1;
        hold_id  = rsp_id;
        hold_out = rsp_out;
        check_rsp("bp fill", 2'd0, 16'd1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rsp_ready = 1'b0;
            #1;
            chk($sformatf("bp%0d req_ready", k), 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
            check_rsp($sformatf("bp%0d", k), 2'd0, 16'd1, 1'b0, 1'b0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        chk("bp release req_ready", 32'(req_ready), 32'b010);
        @(posedge clk);
        #1;
        check_rsp("bp release", 2'd1, 16'd2, 1'b0, 1'b0);

        // Reset with buffer full and pointer at 2
        @(negedge clk);
        req_valid = 3'b000;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("prerst rsp_valid", 32'(rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst rsp_valid", 32'(rsp_valid), 32'd0);
        req_valid = 3'b111;
        rsp_ready = 1'b1;
        #1;
        chk("in rst req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 3'b101;
        #1;
        chk("post rst req_ready", 32'(req_ready), 32'b001);
        @(posedge clk);
        #1;
        check_rsp("post rst", 2'd0, 16'd1, 1'b0, 1'b0);

        // Only requester 2 active: granted every cycle
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req_valid = 3'b100;
            #1;
            chk($sformatf("solo%0d req_ready", k), 32'(req_ready), 32'b100);
            @(posedge clk);
            #1;
            check_rsp($sformatf("solo%0d", k), 2'd2, 16'd3, 1'b0, 1'b0);
        end

        @(negedge clk);
        req_valid = '0;
        if (hold_id != 2'd0 || hold_out != 16'd1) begin
            n_checks++;
            n_errors++;
            $display("FAIL bp hold capture: got id %0h out %0h expected id 0 out 1", hold_id, hold_out);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one 16-bit signed add/subtract datapath between NUM_REQ requesters, e.g. the PC incrementer, the branch-target adder and the ALU address path.
- Round-robin arbiter: at most one operation accepted per cycle.
- Result, carry, overflow and requester ID are registered into a single-entry response buffer with valid/ready backpressure.

Parameters:
- WIDTH, 16, operand/result width in bits.
- NUM_REQ, 3, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester operation request.
- req_op  input  NUM_REQ  per-requester op; 1 = subtract (x - y), 0 = add.
- req_x  input  NUM_REQ*WIDTH  flattened x operands; requester i uses bits [i*WIDTH +: WIDTH].
- req_y  input  NUM_REQ*WIDTH  flattened y operands, same packing.
- req_ready  output  NUM_REQ  one-hot grant, combinational.
- rsp_valid  output  1  response buffer holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  ID_W  index of the requester that owns the result.
- rsp_out  output  WIDTH  result.
- rsp_cout  output  1  carry out of the MSB.
- rsp_ov  output  1  signed overflow.

Behaviour:
- Reset (async, Rst_n = 0):
  - rsp_valid = 0; rsp_id, rsp_out, rsp_cout and rsp_ov = 0.
  - Round-robin pointer = 0.
  - req_ready = 0 while in reset.
- Arithmetic:
  - yy = y XOR {WIDTH{op}}.
  - sum = x + yy + op, computed at WIDTH+1 bits.
  - out = sum[WIDTH-1:0]; cout = sum[WIDTH].
  - ov = cout XOR carry into bit WIDTH-1.
  - For subtract, cout = 1 means no borrow (unsigned x >= y).
- Buffer states:
  - EMPTY (rsp_valid = 0), FULL (rsp_valid = 1).
  - can_accept = !rsp_valid || rsp_ready.
- Grant:
  - When can_accept is high and any req_valid is set, grant the first valid requester scanning from pointer upward, modulo NUM_REQ.
  - req_ready is high for that requester only; all others are 0.
  - No grant when can_accept = 0.
- Handshake:
  - Transfer occurs when req_valid[i] && req_ready[i].
  - Requesters must hold valid, op, x and y stable until granted.
  - req_valid must not depend on req_ready.
- Latency: one cycle. Operands accepted at edge N appear on rsp_* after edge N with rsp_valid = 1.
- Pointer update: on a grant to i, pointer <= (i+1) mod NUM_REQ. Without a grant, the pointer holds.
- Transitions:
  - EMPTY + grant -> FULL.
  - FULL + rsp_ready + grant -> FULL with the new result (back-to-back, full throughput).
  - FULL + rsp_ready + no grant -> EMPTY.
  - FULL + !rsp_ready -> FULL; all rsp_* outputs held stable.
- Out-of-range fields: requester indices >= NUM_REQ are never granted. An unused rsp_id encoding never appears.
- Reset mid-operation: any in-flight response is discarded, rsp_valid drops immediately (asynchronous), and the pointer returns to 0.

Optional Feature:
- Macro: ADDER_ARB_SAT_EN.
- Defined: when ov = 1, rsp_out saturates.
  - If x[WIDTH-1] = 0, rsp_out = 0x7FFF (max positive).
  - Otherwise rsp_out = 0x8000 (max negative).
  - rsp_ov and rsp_cout still report the raw flags.
- Undefined: rsp_out is the wrapped result. No saturation logic is synthesized.

Test Plan:
- Requester 0 adds 0x7FFF + 0x0001, rsp_ready = 1 -> next cycle rsp_valid = 1, rsp_id = 0, rsp_out = 0x8000 (0x7FFF with SAT_EN), rsp_ov = 1, rsp_cout = 0.
- Requester 1 subtracts 0x0005 - 0x0007 -> rsp_out = 0xFFFE, rsp_cout = 0, rsp_ov = 0, rsp_id = 1. Requester 2 subtracts 0x8000 - 0x0001 -> rsp_out = 0x7FFF (0x8000 with SAT_EN), rsp_ov = 1, rsp_cout = 1.
- All three req_valid held high for six cycles, rsp_ready = 1 -> grant order 0,1,2,0,1,2 with one response per cycle and no bubbles.
- Response FULL, rsp_ready = 0 for 3 cycles while requests pend -> req_ready = 0 and rsp_* unchanged. rsp_ready = 1 -> same-cycle grant to the next round-robin requester.
- Rst_n asserted while rsp_valid = 1 and the pointer is at 2 -> rsp_valid = 0 with no clock edge. After release, simultaneous requests 0 and 2 grant 0 first.
- Only requester 2 active, repeatedly -> granted every cycle. The pointer wraps to 0 each time and no other requester's req_ready goes high.
